nonlinear_job_scheduler: RTL and testbench

//  Queues activation jobs (pooling or sigmoid/tanh) and runs them one at a time on the nonlinear block.

---
 rtl/nonlinear_job_scheduler.sv | 160 ++++++++++++++++
 tb/tb_nonlinear_job_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/nonlinear_job_scheduler.sv
// Job queue and sequencer for the nonlinear activation block: pops one descriptor at a time,
// drives config/enable, waits for finish (or timeout) and arbitrates external LUT writes.
module nonlinear_job_scheduler #(
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 2**20,
   localparam int         PW             = $clog2(FIFO_DEPTH),
   localparam int         CW             = PW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          job_valid,
   output logic          job_ready,
   input  logic          job_mode,
   input  logic [2:0]    job_type,
   input  logic [31:0]   job_cycles,
   input  logic [7:0]    job_shift,
   input  logic          lut_wr_req,
   input  logic [5:0]    lut_wr_addr,
   input  logic [7:0]    lut_wr_data,
   output logic          lut_wr_gnt,
   output logic          enable_nonlinear_block,
   output logic          enable_pooling,
   output logic          enable_sig_tanh,
   output logic [2:0]    type_nonlinear_function,
   output logic [31:0]   NUMBER_OF_ACTIVATION_CYCLES,
   output logic [7:0]    SHIFT_FIXED_POINT,
   output logic          wr_en_ext_lut,
   output logic [5:0]    wr_addr_ext_lut,
   output logic [7:0]    wr_data_ext_lut,
   input  logic          finished_activation,
   input  logic          clear_err,
   output logic          busy,
   output logic          job_done,
   output logic          job_err,
   output logic          timeout_err,
   output logic [CW-1:0] fifo_count
);

   typedef struct packed {
      logic        mode;
      logic [2:0]  typ;
      logic [31:0] cycles;
      logic [7:0]  shift;
   } job_t;

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   job_t          mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   state_t        state_q;
   logic [31:0]   run_cnt_q;

   logic          en_q, pool_q, sig_q, done_q, err_q, terr_q, wr_en_q;
   logic [2:0]    type_q;
   logic [31:0]   cycles_q;
   logic [7:0]    shift_q;
   logic [5:0]    wr_addr_q;
   logic [7:0]    wr_data_q;

   logic full, empty, push, pop, timeout_hit;

   assign full        = (count_q == CW'(FIFO_DEPTH));
   assign empty       = (count_q == '0);
   // Combinational handshakes are gated by reset so every output reads 0 while it is held.
   assign job_ready   = reset & ~full;
   assign push        = job_valid & job_ready;
   assign lut_wr_gnt  = reset & lut_wr_req & (state_q == IDLE) & empty;
   assign pop         = reset & (state_q == IDLE) & ~empty & ~lut_wr_gnt;
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (run_cnt_q == 32'(TIMEOUT_CYCLES - 1));

   assign busy                        = (state_q != IDLE) | ~empty;
   assign fifo_count                  = count_q;
   assign enable_nonlinear_block      = en_q;
   assign enable_pooling              = pool_q;
   assign enable_sig_tanh             = sig_q;
   assign type_nonlinear_function     = type_q;
   assign NUMBER_OF_ACTIVATION_CYCLES = cycles_q;
   assign SHIFT_FIXED_POINT           = shift_q;
   assign wr_en_ext_lut               = wr_en_q;
   assign wr_addr_ext_lut             = wr_addr_q;
   assign wr_data_ext_lut             = wr_data_q;
   assign job_done                    = done_q;
   assign job_err                     = err_q;
   assign timeout_err                 = terr_q;

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= '{mode: job_mode, typ: job_type, cycles: job_cycles, shift: job_shift};
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         state_q   <= IDLE;
         run_cnt_q <= '0;
         en_q      <= 1'b0;
         pool_q    <= 1'b0;
         sig_q     <= 1'b0;
         type_q    <= '0;
         cycles_q  <= '0;
         shift_q   <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         terr_q    <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         wr_en_q <= lut_wr_gnt;
         if (lut_wr_gnt) begin
            wr_addr_q <= lut_wr_addr;
            wr_data_q <= lut_wr_data;
         end
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push && !pop)      count_q <= count_q + 1'b1;
         else if (!push && pop) count_q <= count_q - 1'b1;
         // A timeout on the same edge overrides the clear below.
         if (clear_err) terr_q <= 1'b0;
         case (state_q)
            IDLE: if (pop) begin
               pool_q   <= ~mem_q[rd_ptr_q].mode;
               sig_q    <= mem_q[rd_ptr_q].mode;
               type_q   <= mem_q[rd_ptr_q].typ;
               cycles_q <= mem_q[rd_ptr_q].cycles;
               shift_q  <= mem_q[rd_ptr_q].shift;
               state_q  <= LOAD;
            end
            LOAD: if (cycles_q == '0) begin
               done_q  <= 1'b1;
               state_q <= DONE;
            end else begin
               en_q      <= 1'b1;
               run_cnt_q <= '0;
               state_q   <= RUN;
            end
            RUN: if (finished_activation) begin
               en_q    <= 1'b0;
               done_q  <= 1'b1;
               state_q <= DONE;
            end else if (timeout_hit) begin
               en_q    <= 1'b0;
               done_q  <= 1'b1;
               err_q   <= 1'b1;
               terr_q  <= 1'b1;
               state_q <= DONE;
            end else begin
               run_cnt_q <= run_cnt_q + 32'd1;
            end
            DONE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nonlinear_job_scheduler.sv
// Scoreboard bench for nonlinear_job_scheduler: expected retirements are queued at push time
// and checked by an independent monitor on each job_done; directed checks cover timing and LUT.
module tb_nonlinear_job_scheduler;
   localparam int TO = 20;

   logic        clk = 0, reset = 0;
   logic        job_valid = 0, job_mode = 0;
   logic [2:0]  job_type = 0;
   logic [31:0] job_cycles = 0;
   logic [7:0]  job_shift = 0;
   logic        lut_wr_req = 0;
   logic [5:0]  lut_wr_addr = 0;
   logic [7:0]  lut_wr_data = 0;
   logic        clear_err = 0;
   logic        finished_activation;
   logic        job_ready, lut_wr_gnt, enable_nonlinear_block, enable_pooling, enable_sig_tanh;
   logic [2:0]  type_nonlinear_function;
   logic [31:0] NUMBER_OF_ACTIVATION_CYCLES;
   logic [7:0]  SHIFT_FIXED_POINT;
   logic        wr_en_ext_lut;
   logic [5:0]  wr_addr_ext_lut;
   logic [7:0]  wr_data_ext_lut;
   logic        busy, job_done, job_err, timeout_err;
   logic [2:0]  fifo_count;

   nonlinear_job_scheduler #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .job_valid(job_valid), .job_ready(job_ready), .job_mode(job_mode),
      .job_type(job_type), .job_cycles(job_cycles), .job_shift(job_shift),
      .lut_wr_req(lut_wr_req), .lut_wr_addr(lut_wr_addr), .lut_wr_data(lut_wr_data), .lut_wr_gnt(lut_wr_gnt),
      .enable_nonlinear_block(enable_nonlinear_block), .enable_pooling(enable_pooling),
      .enable_sig_tanh(enable_sig_tanh), .type_nonlinear_function(type_nonlinear_function),
      .NUMBER_OF_ACTIVATION_CYCLES(NUMBER_OF_ACTIVATION_CYCLES), .SHIFT_FIXED_POINT(SHIFT_FIXED_POINT),
      .wr_en_ext_lut(wr_en_ext_lut), .wr_addr_ext_lut(wr_addr_ext_lut), .wr_data_ext_lut(wr_data_ext_lut),
      .finished_activation(finished_activation), .clear_err(clear_err), .busy(busy),
      .job_done(job_done), .job_err(job_err), .timeout_err(timeout_err), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  typ;
      logic [31:0] cyc;
      logic [7:0]  sh;
      logic        pool;
      logic        sig;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   total = 0, bad = 0;
   int   en_cnt = 0, en_run = 0, done_seen = 0;
   logic auto_fin = 0, fin_auto = 0, fin_man = 0;

   assign finished_activation = fin_man | fin_auto;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Counts enable-high cycles and, when auto_fin is set, answers each run with a finish pulse.
   always @(negedge clk) begin
      en_cnt   <= en_cnt + (enable_nonlinear_block ? 1 : 0);
      en_run   <= enable_nonlinear_block ? en_run + 1 : 0;
      fin_auto <= auto_fin && enable_nonlinear_block && (en_run >= 2);
   end

   always @(negedge clk) begin : monitor
      exp_t e;
      if (reset && job_done) begin
         done_seen <= done_seen + 1;
         if (sb.size() == 0) chk("unexpected_done", 1, 0);
         else begin
            e = sb.pop_front();
            chk("done_cfg", {type_nonlinear_function, NUMBER_OF_ACTIVATION_CYCLES, SHIFT_FIXED_POINT,
                             enable_pooling, enable_sig_tanh}, {e.typ, e.cyc, e.sh, e.pool, e.sig});
            chk("done_err", job_err, e.err);
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic push_job(input logic m, input logic [2:0] t, input logic [31:0] c,
                           input logic [7:0] s, input logic err, output int waited);
      logic acc;
      waited = 0;
      job_valid = 1; job_mode = m; job_type = t; job_cycles = c; job_shift = s;
      do begin
         @(negedge clk); acc = job_ready;
         @(posedge clk); #1;
         if (!acc) waited++;
      end while (!acc && waited < 50);
      job_valid = 0;
      if (acc) sb.push_back(exp_t'{t, c, s, ~m, m, err});
      else chk("push_timeout", 0, 1);
   endtask

   task automatic wait_done(input int max, output int n);
      n = 0;
      do begin @(negedge clk); n++; end while (!job_done && n < max);
      if (!job_done) chk("done_timeout", 0, 1);
   endtask

   task automatic wait_en(input int max, output int n);
      n = 0;
      do begin @(negedge clk); n++; end while (!enable_nonlinear_block && n < max);
      if (!enable_nonlinear_block) chk("enable_timeout", 0, 1);
   endtask

   initial begin
      int n, w, g, base;
      // 1. reset with stimulus active
      job_valid = 1; lut_wr_req = 1; job_cycles = 7;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_outs", {job_ready, lut_wr_gnt, enable_nonlinear_block, enable_pooling, enable_sig_tanh,
                       type_nonlinear_function, NUMBER_OF_ACTIVATION_CYCLES, SHIFT_FIXED_POINT,
                       wr_en_ext_lut, wr_addr_ext_lut, wr_data_ext_lut, busy, job_done, job_err, timeout_err}, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_ready", job_ready, 0);
      job_valid = 0; lut_wr_req = 0;
      step(); reset = 1;
      @(negedge clk); chk("ready_after_rst", job_ready, 1);

      // 2. single pooling job, finish 16 cycles after enable
      step();
      base = en_cnt;
      push_job(0, 3'd2, 32'd16, 8'd4, 0, w);
      wait_en(10, n);
      chk("enable_latency", n, 3);
      repeat (16) @(posedge clk);
      #1 fin_man = 1;
      @(posedge clk); #1 fin_man = 0;
      wait_done(5, n);
      chk("enable_len", en_cnt - base, 17);
      @(negedge clk); chk("busy_after", busy, 0);

      // 3. stalled job A, then 5 back-to-back jobs; the last is held off while the queue is full
      step();
      push_job(0, 3'd1, 32'd5, 8'd1, 0, w);
      wait_en(10, n);
      step();
      push_job(1, 3'd3, 32'd3, 8'd2, 0, w);
      push_job(0, 3'd4, 32'd4, 8'd3, 0, w);
      push_job(1, 3'd5, 32'd5, 8'd4, 0, w);
      push_job(0, 3'd6, 32'd6, 8'd5, 0, w);
      job_valid = 1; job_mode = 1; job_type = 3'd7; job_cycles = 32'd7; job_shift = 8'd6;
      @(negedge clk);
      chk("full_ready", job_ready, 0);
      chk("full_count", fifo_count, 4);
      step();
      auto_fin = 1;
      push_job(1, 3'd7, 32'd7, 8'd6, 0, w);
      chk("held_off", (w > 0), 1);
      n = 0;
      do begin @(negedge clk); n++; end while ((sb.size() != 0 || busy) && n < 200);
      chk("drain_sb", sb.size(), 0);
      chk("drain_busy", busy, 0);
      auto_fin = 0;

      // 4. zero-cycle job skips RUN
      step();
      base = en_cnt;
      push_job(1, 3'd0, 32'd0, 8'd9, 0, w);
      wait_done(10, n);
      chk("zero_done_lat", n, 3);
      chk("zero_no_enable", en_cnt - base, 0);
      repeat (2) @(negedge clk);

      // 5. timeout with no finish
      step();
      base = en_cnt;
      push_job(0, 3'd3, 32'd100, 8'd1, 1, w);
      wait_done(60, n);
      chk("to_enable_len", en_cnt - base, TO);
      chk("to_flag", timeout_err, 1);
      repeat (5) @(negedge clk);
      chk("to_sticky", timeout_err, 1);
      step(); clear_err = 1;
      step(); clear_err = 0;
      @(negedge clk); chk("to_cleared", timeout_err, 0);

      // 6. LUT write blocked while a job is queued or running, granted once drained
      step();
      auto_fin = 1;
      push_job(0, 3'd1, 32'd5, 8'd0, 0, w);
      lut_wr_req = 1; lut_wr_addr = 6'h2A; lut_wr_data = 8'hFB;
      @(negedge clk); chk("gnt_queued", lut_wr_gnt, 0);
      n = 0; g = 0;
      do begin @(negedge clk); n++; if (lut_wr_gnt) g++; end while (!job_done && n < 30);
      chk("gnt_busy", g, 0);
      n = 0;
      do begin @(negedge clk); n++; end while (!lut_wr_gnt && n < 10);
      chk("gnt_idle", lut_wr_gnt, 1);
      @(posedge clk); #1 lut_wr_req = 0;
      @(negedge clk);
      chk("lut_wr", {wr_en_ext_lut, wr_addr_ext_lut, wr_data_ext_lut}, {1'b1, 6'h2A, 8'hFB});
      @(negedge clk); chk("lut_wr_pulse", wr_en_ext_lut, 0);
      auto_fin = 0;

      // reset in the middle of RUN drops the job silently
      step();
      push_job(1, 3'd5, 32'd50, 8'd7, 0, w);
      wait_en(10, n);
      step(); step(); step();
      reset = 0;
      step();
      sb.delete();
      reset = 1;
      base = done_seen;
      @(negedge clk);
      chk("midrst_state", {enable_nonlinear_block, busy, fifo_count, job_done}, 0);
      repeat (30) @(negedge clk);
      chk("midrst_no_done", done_seen - base, 0);
      chk("sb_empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1);
   end
endmodule
